// File: rtl/xmm_pkg.sv
// Shared constants and types for the XMM fixed-point write-back path.
package xmm_pkg;
  localparam int NUM_REQ_DEF = 3;
  localparam int REQ_ALU     = 0;
  localparam int REQ_MUL     = 1;
  localparam int REQ_DIV     = 2;
  localparam int REG_AW      = 5;
  localparam int DATA_W      = 64;
  localparam int NUM_REGS    = 1 << REG_AW;

  // One registered write-back slot feeding the register file.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_stage_t;
endpackage

// File: rtl/xmm_rr_arbiter.sv
// Round-robin one-hot grant; search begins one past the last granted requester.
module xmm_rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 1; i <= N; i++) begin
      // last_grant < N and i <= N, so one subtraction is enough to wrap
      w_sum = {1'b0, last_grant} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
      w_idx = w_sum[IW-1:0];
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end
endmodule

// File: rtl/xmm_writeback_arbiter.sv
// Arbitrates ALU/MUL/DIV results onto the single XMM register-file write port
// and tracks pending destinations in a busy scoreboard for issue hazards.
module xmm_writeback_arbiter
  import xmm_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_AW-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_addr,
  output logic                      issue_ready,
  input  logic [REG_AW-1:0]         read_addr1,
  input  logic [REG_AW-1:0]         read_addr2,
  input  logic [REG_AW-1:0]         read_addr3,
  output logic                      hazard,
  output logic                      should_write,
  output logic [REG_AW-1:0]         write_addr,
  output logic [DATA_W-1:0]         write_data
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REGS-1:1] r_busy;
  logic [IW-1:0]       r_last_grant;
  wb_stage_t           r_wb;

  logic [NUM_REGS-1:0] w_busy, w_busy_nxt;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IW-1:0]       w_gidx;
  logic                w_xfer, w_issue;
  logic                w_haz1, w_haz2, w_haz3;
  logic [REG_AW-1:0]   w_addr_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*REG_AW +: REG_AW];
    assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  xmm_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req        (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_gidx)
  );

  assign req_ready = reset ? w_grant : '0;
  assign w_xfer    = |req_ready;
  assign w_busy    = {r_busy, 1'b0};

  assign should_write = r_wb.vld && (r_wb.addr != '0);
  assign write_addr   = r_wb.addr;
  assign write_data   = r_wb.data;

  // A result sitting in the output stage is not yet readable from the file.
  assign w_haz1 = w_busy[read_addr1] || (should_write && write_addr == read_addr1 && read_addr1 != '0);
  assign w_haz2 = w_busy[read_addr2] || (should_write && write_addr == read_addr2 && read_addr2 != '0);
  assign w_haz3 = w_busy[read_addr3] || (should_write && write_addr == read_addr3 && read_addr3 != '0);
  assign hazard = w_haz1 || w_haz2 || w_haz3;

  assign issue_ready = !w_busy[issue_addr] && !hazard;
  assign w_issue     = issue_valid && issue_ready;

  // Clear first, then set, so a same-edge issue keeps the register busy.
  always_comb begin
    w_busy_nxt = w_busy;
    if (w_xfer)  w_busy_nxt[w_addr_arr[w_gidx]] = 1'b0;
    if (w_issue) w_busy_nxt[issue_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy       <= '0;
      r_last_grant <= IW'(NUM_REQ-1);
      r_wb         <= '0;
    end else begin
      r_busy  <= w_busy_nxt[NUM_REGS-1:1];
      r_wb.vld <= w_xfer;
      if (w_xfer) begin
        r_last_grant <= w_gidx;
        r_wb.addr    <= w_addr_arr[w_gidx];
        r_wb.data    <= w_data_arr[w_gidx];
      end
    end
  end
endmodule

// File: tb/tb_xmm_writeback_arbiter.sv
// Directed bench for the XMM write-back arbiter and busy scoreboard.
module tb_xmm_writeback_arbiter;
  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*5-1:0]  req_addr;
  logic [N*64-1:0] req_data;
  logic            issue_valid;
  logic [4:0]      issue_addr;
  logic            issue_ready;
  logic [4:0]      read_addr1, read_addr2, read_addr3;
  logic            hazard;
  logic            should_write;
  logic [4:0]      write_addr;
  logic [63:0]     write_data;

  int checks   = 0;
  int failures = 0;

  xmm_writeback_arbiter #(.NUM_REQ(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .issue_ready  (issue_ready),
    .read_addr1   (read_addr1),
    .read_addr2   (read_addr2),
    .read_addr3   (read_addr3),
    .hazard       (hazard),
    .should_write (should_write),
    .write_addr   (write_addr),
    .write_data   (write_data)
  );

  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]       = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    read_addr1  = '0;
    read_addr2  = '0;
    read_addr3  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    req_valid = 3'b111;
    read_addr1 = 5'd5;
    #2;
    checks++; if (should_write !== 1'b0) begin failures++; $display("FAIL reset_should_write got=%0b exp=0", should_write); end
    checks++; if (write_addr !== 5'd0) begin failures++; $display("FAIL reset_write_addr got=%0d exp=0", write_addr); end
    checks++; if (write_data !== 64'd0) begin failures++; $display("FAIL reset_write_data got=%h exp=0", write_data); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_req_ready got=%b exp=000", req_ready); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
    tick();
    do_reset();
  endtask

  task automatic test_issue();
    issue_valid = 1'b1; issue_addr = 5'd5;
    read_addr1 = 5'd1; read_addr2 = 5'd2; read_addr3 = 5'd3;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL issue_first got=%0b exp=1", issue_ready); end
    tick();
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL issue_second got=%0b exp=0", issue_ready); end
    issue_valid = 1'b0;
    read_addr1 = 5'd5;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL issue_busy5 got=%0b exp=1", hazard); end
    read_addr1 = 5'd1;
  endtask

  task automatic test_writeback();
    set_req(0, 1'b1, 5'd5, 64'h0001_0000_0000_0000);
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL wb_ready got=%b exp=001", req_ready); end
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0);
    #1;
    checks++; if (should_write !== 1'b1) begin failures++; $display("FAIL wb_should_write got=%0b exp=1", should_write); end
    checks++; if (write_addr !== 5'd5) begin failures++; $display("FAIL wb_addr got=%0d exp=5", write_addr); end
    checks++; if (write_data !== 64'h0001_0000_0000_0000) begin failures++; $display("FAIL wb_data got=%h exp=0001000000000000", write_data); end
    tick();
    read_addr1 = 5'd5;
    #1;
    checks++; if (should_write !== 1'b0) begin failures++; $display("FAIL wb_single_pulse got=%0b exp=0", should_write); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL wb_busy5_cleared got=%0b exp=0", hazard); end
    read_addr1 = 5'd0;
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_rdy [3];
    logic [4:0]  exp_addr[3];
    logic [63:0] exp_data[3];
    exp_rdy  = '{3'b001, 3'b010, 3'b100};
    exp_addr = '{5'd4, 5'd6, 5'd7};
    exp_data = '{64'h11, 64'h22, 64'h33};
    do_reset();
    set_req(0, 1'b1, 5'd4, 64'h11);
    set_req(1, 1'b1, 5'd6, 64'h22);
    set_req(2, 1'b1, 5'd7, 64'h33);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (req_ready !== exp_rdy[k]) begin failures++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp_rdy[k]); end
      tick();
      if (k == 2) req_valid = '0;
      #1;
      checks++; if (should_write !== 1'b1 || write_addr !== exp_addr[k] || write_data !== exp_data[k])
        begin failures++; $display("FAIL rr_write%0d got=%0b/%0d/%h exp=1/%0d/%h", k, should_write, write_addr, write_data, exp_addr[k], exp_data[k]); end
    end
    tick();
    checks++; if (should_write !== 1'b0) begin failures++; $display("FAIL rr_drain got=%0b exp=0", should_write); end
  endtask

  task automatic test_hazard();
    do_reset();
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    issue_valid = 1'b1; issue_addr = 5'd10;
    read_addr2 = 5'd9;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL hz_busy got=%0b exp=1", hazard); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL hz_issue_blocked got=%0b exp=0", issue_ready); end
    issue_valid = 1'b0;
    set_req(1, 1'b1, 5'd9, 64'hDEAD_BEEF);
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL hz_grant got=%b exp=010", req_ready); end
    tick();
    set_req(1, 1'b0, 5'd0, 64'd0);
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL hz_inflight got=%0b exp=1", hazard); end
    tick();
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL hz_clear got=%0b exp=0", hazard); end
    read_addr2 = 5'd0;
  endtask

  task automatic test_same_edge();
    do_reset();
    issue_valid = 1'b1; issue_addr = 5'd8;
    set_req(2, 1'b1, 5'd8, 64'h0123_4567_89AB_CDEF);
    #1;
    checks++; if (issue_ready !== 1'b1 || req_ready !== 3'b100)
      begin failures++; $display("FAIL se_fire got=%0b/%b exp=1/100", issue_ready, req_ready); end
    tick();
    issue_valid = 1'b0;
    set_req(2, 1'b0, 5'd0, 64'd0);
    tick();
    read_addr1 = 5'd8;
    #1;
    checks++; if (hazard !== 1'b1) begin failures++; $display("FAIL se_set_wins got=%0b exp=1", hazard); end
    set_req(0, 1'b1, 5'd0, 64'hAAAA);
    tick();
    set_req(0, 1'b0, 5'd0, 64'd0);
    #1;
    checks++; if (should_write !== 1'b0) begin failures++; $display("FAIL se_r0_write got=%0b exp=0", should_write); end
    checks++; if (write_data !== 64'hAAAA) begin failures++; $display("FAIL se_r0_data got=%h exp=aaaa", write_data); end
  endtask

  task automatic test_reset_mid();
    // busy[8] is still set from the previous scenario
    set_req(1, 1'b1, 5'd12, 64'h55);
    tick();
    set_req(1, 1'b0, 5'd0, 64'd0);
    reset = 1'b0;
    set_req(0, 1'b1, 5'd1, 64'h1);
    set_req(1, 1'b1, 5'd2, 64'h2);
    set_req(2, 1'b1, 5'd3, 64'h3);
    #1;
    checks++; if (should_write !== 1'b0) begin failures++; $display("FAIL rm_should_write got=%0b exp=0", should_write); end
    checks++; if (hazard !== 1'b0) begin failures++; $display("FAIL rm_busy_cleared got=%0b exp=0", hazard); end
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL rm_ready_in_reset got=%b exp=000", req_ready); end
    tick();
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rm_first_grant got=%b exp=001", req_ready); end
    tick();
    checks++; if (should_write !== 1'b1 || write_addr !== 5'd1)
      begin failures++; $display("FAIL rm_first_write got=%0b/%0d exp=1/1", should_write, write_addr); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_issue();
    test_writeback();
    test_round_robin();
    test_hazard();
    test_same_edge();
    test_reset_mid();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/xmm_writeback_arbiter.md
XMM_WRITEBACK_ARBITER -- requirements
Module: xmm_writeback_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, meaning number of fixed-point result producers (0=ALU, 1=MUL, 2=DIV).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 SHALL have port req_valid  input  NUM_REQ  per-requester write-back request.
REQ-005 SHALL have port req_ready  output  NUM_REQ  per-requester grant; transfer occurs when valid and ready are both 1.
REQ-006 SHALL have port req_addr  input  NUM_REQ*5  packed destination register per requester.
REQ-007 SHALL have port req_data  input  NUM_REQ*64  packed q15.48 result per requester.
REQ-008 SHALL have port issue_valid  input  1  a new op claims destination issue_addr.
REQ-009 SHALL have port issue_addr  input  5  destination of the issuing op.
REQ-010 SHALL have port issue_ready  output  1  issue accepted this cycle.
REQ-011 SHALL have port read_addr1/2/3  input  5 each  source operands of the issuing op.
REQ-012 SHALL have port hazard  output  1  at least one source register has a pending write.
REQ-013 SHALL have port should_write  output  1  register-file write enable.
REQ-014 SHALL have port write_addr  output  5  register-file write address.
REQ-015 SHALL have port write_data  output  64  register-file write data.

Function
REQ-016 SHALL keep a 32-bit busy scoreboard; bit 0 is constant 0.
REQ-017 SHALL assert issue_ready = !busy[issue_addr] && !hazard (combinational); issue_addr 0 always ready for the busy term.
REQ-018 SHALL set busy[issue_addr] on rising edge when issue_valid && issue_ready && issue_addr != 0.
REQ-019 SHALL grant at most one requester per cycle, round-robin: search starts at (last_grant+1) mod NUM_REQ; last_grant updates only on a transfer.
REQ-020 SHALL drive req_ready one-hot or zero, combinationally from req_valid and last_grant; no grant when no valid.
REQ-021 SHALL require requesters to hold valid, addr, data stable until transfer; the block does not buffer beyond one stage.
REQ-022 SHALL capture the granted addr/data into the output stage on transfer; should_write = 1 exactly one cycle after transfer (latency 1), otherwise 0.
REQ-023 SHALL force should_write = 0 when the captured address is 0 (no write to register 0); write_addr/write_data still hold captured values.
REQ-024 SHALL clear busy[addr] on the transfer edge for the granted address.
REQ-025 SHALL let set win when issue and clear target the same address on the same edge (busy stays 1).
REQ-026 SHALL compute hazard = OR over k of (busy[read_addrk] || (should_write && write_addr == read_addrk && read_addrk != 0)), covering the in-flight output stage.
REQ-027 SHALL ignore req_valid for addresses not marked busy (still granted and written; scoreboard unchanged).

Reset
REQ-028 SHALL, while reset == 0, asynchronously clear busy to all-zero, last_grant to NUM_REQ-1 (so requester 0 wins first), should_write to 0, write_addr to 0, write_data to 0.
REQ-029 SHALL drop any captured-but-unwritten result on reset mid-operation; req_ready is 0 during reset.
REQ-030 SHALL release reset synchronously-safe: first grant possible on the first rising edge with reset == 1.

Structure
REQ-031 SHALL place NUM_REQ default, requester index constants (ALU/MUL/DIV), register-address width 5 and data width 64 in a shared package xmm_pkg.
REQ-032 SHALL implement the round-robin grant logic as sub-module xmm_rr_arbiter (req, last_grant -> one-hot grant); scoreboard and output stage stay in the top.
REQ-033 SHALL connect write port directly to XMM register file should_write/write_addr/write_data.

Verification
REQ-034 Issue addr 5 with reads 1,2,3 idle -> issue_ready=1, busy[5]=1 next cycle; second issue to 5 -> issue_ready=0.
REQ-035 busy[5] set; ALU req addr 5 data 0x0001_0000_0000_0000 -> req_ready[0]=1 same cycle, should_write=1, write_addr=5, write_data=0x0001_0000_0000_0000 next cycle, busy[5]=0.
REQ-036 All three requesters valid continuously (addrs 4,6,7) after reset -> grants in order 0,1,2, one per cycle, should_write high three consecutive cycles.
REQ-037 busy[9] set, read_addr2=9 -> hazard=1, issue_ready=0; after transfer to 9, hazard=1 one more cycle (output stage), then 0.
REQ-038 Same-edge issue of addr 8 and transfer of addr 8 -> busy[8]=1 after edge; request to addr 0 -> should_write stays 0.
REQ-039 Reset pulled low the cycle after a transfer -> should_write=0 immediately, busy all 0, next grant to requester 0.
